// File: rtl/load_store_unit_pkg.sv
// Shared MEM-stage control types: load/store width select, LSU FSM states and
// the width helpers used to form byte enables and store data.
package HighLevelControl;

    typedef enum logic [2:0] {
        NONE               = 3'd0,
        BYTE               = 3'd1,
        HALF_WORD          = 3'd2,
        WORD               = 3'd3,
        BYTE_UNSIGNED      = 3'd4,
        HALF_WORD_UNSIGNED = 3'd5
    } truncSrc;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        DRAIN
    } lsuState;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_e;

    // NONE and the unused codes fall through to a full word.
    function automatic acc_size_e access_size(input truncSrc t);
        case (t)
            BYTE, BYTE_UNSIGNED:           return SZ_BYTE;
            HALF_WORD, HALF_WORD_UNSIGNED: return SZ_HALF;
            default:                       return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input acc_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input acc_size_e sz, input logic [31:0] d);
        case (sz)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load data alignment: shift the addressed byte lane down and
// sign- or zero-extend to the requested width.
module load_extend
    import HighLevelControl::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      byte_off,
    input  logic [2:0]      trunc_src,
    output logic [XLEN-1:0] ext_data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {byte_off, 3'b000};
        case (truncSrc'(trunc_src))
            BYTE:               ext_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            HALF_WORD:          ext_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            BYTE_UNSIGNED:      ext_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            HALF_WORD_UNSIGNED: ext_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default:            ext_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: issues one word-addressed req/gnt/rvalid access per
// instruction, stalls the pipeline while it is in flight, returns extended load data.
module load_store_unit
    import HighLevelControl::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      trunc_src,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    input  logic            flush,
    output logic            stall,
    output logic [XLEN-1:0] load_result,
    output logic            result_valid,
    output logic            misaligned,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata
);

    lsuState         state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [2:0]      trunc_q, trunc_d;
    logic [1:0]      off_q, off_d;
    logic [XLEN-1:0] load_result_q, load_result_d;
    logic            result_valid_q, result_valid_d;

    logic            access;
    logic            mis;
    acc_size_e       sz;
    logic [XLEN-1:0] ext_data;

    assign access = (mem_read | mem_write) & ~flush;
    assign sz     = access_size(truncSrc'(trunc_src));
    assign mis    = is_misaligned(sz, addr[1:0]);

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata    (dmem_rdata),
        .byte_off (off_q),
        .trunc_src(trunc_q),
        .ext_data (ext_data)
    );

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        trunc_d        = trunc_q;
        off_d          = off_q;
        load_result_d  = load_result_q;
        result_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && mis) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    load_result_d  = '0;
                end else if (access) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = {addr[XLEN-1:2], 2'b00};
                    be_d    = byte_enables(sz, addr[1:0]);
                    wdata_d = replicate(sz, store_data);
                    trunc_d = trunc_src;
                    off_d   = addr[1:0];
                end
            end
            REQ: begin
                // A granted store has committed even if the instruction is
                // flushed in the same cycle; a granted load must drain.
                if (dmem_gnt) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d        = DONE;
                        result_valid_d = 1'b1;
                    end else begin
                        state_d = flush ? DRAIN : WAIT;
                    end
                end else if (flush) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d        = DONE;
                        result_valid_d = 1'b1;
                        load_result_d  = ext_data;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dmem_rvalid) state_d = IDLE;
            end
            DONE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            trunc_q        <= '0;
            off_q          <= '0;
            load_result_q  <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            be_q           <= be_d;
            wdata_q        <= wdata_d;
            trunc_q        <= trunc_d;
            off_q          <= off_d;
            load_result_q  <= load_result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign stall        = ((state_q == IDLE) && access) || (state_q == REQ) ||
                          (state_q == WAIT) || (state_q == DRAIN);
    assign misaligned   = (state_q == IDLE) && access && mis && !reset;
    assign result_valid = result_valid_q;
    assign load_result  = load_result_q;
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;

endmodule
